// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the pushbox game: flow-controller state encoding,
// move direction encoding, map geometry and tile codes. The map engine and the
// display logic use the geometry and tile codes; game_flow_ctrl uses the state
// and direction encodings.
// -----------------------------------------------------------------------------
package game_pkg;

    // Flow-controller state encoding, visible on the game_state port.
    localparam logic [2:0] ST_LOAD     = 3'd0;
    localparam logic [2:0] ST_PLAY     = 3'd1;
    localparam logic [2:0] ST_COOLDOWN = 3'd2;
    localparam logic [2:0] ST_WIN      = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        S_LOAD     = ST_LOAD,
        S_PLAY     = ST_PLAY,
        S_COOLDOWN = ST_COOLDOWN,
        S_WIN      = ST_WIN,
        S_DONE     = ST_DONE
    } game_state_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    // Map geometry shared with the map engine and display.
    localparam int MAP_W     = 7;
    localparam int MAP_H     = 8;
    localparam int MAP_CELLS = MAP_W * MAP_H;

    // Tile codes stored in the map.
    localparam logic [3:0] TILE_WALL   = 4'd0;
    localparam logic [3:0] TILE_BOX    = 4'd1;
    localparam logic [3:0] TILE_CHEST  = 4'd2;
    localparam logic [3:0] TILE_FLOOR  = 4'd3;
    localparam logic [3:0] TILE_KEY    = 4'd4;
    localparam logic [3:0] TILE_PLAYER = 4'd6;
    localparam logic [3:0] TILE_GOAL   = 4'd8;

    // Fixed-priority direction pick: up > down > left > right.
    function automatic dir_t pick_dir(input logic up, input logic down,
                                      input logic left, input logic right);
        if (up)         return DIR_UP;
        else if (down)  return DIR_DOWN;
        else if (left)  return DIR_LEFT;
        else if (right) return DIR_RIGHT;
        else            return DIR_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Debounces one already-synchronised button level. The debounced level only
// follows the raw level after the raw level has differed from it for
// DEB_CYCLES consecutive clock cycles; any cycle of agreement restarts the
// count.
//
// Parameters:
//   DEB_CYCLES - consecutive differing cycles required to flip the level
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset (level and counter cleared)
//   raw    - synchronised raw button level
//   level  - debounced button level
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    logic [19:0] cnt_q;

    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            level <= 1'b0;
        end else if (raw == level) begin
            cnt_q <= '0;
        end else if (cnt_q >= DEB_CYCLES - 20'd1) begin
            // This is the DEB_CYCLES-th differing sample: accept the new level.
            level <= raw;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 20'd1;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
// Sequences the pushbox map engine. Debounces the four direction buttons and
// the restart button, arbitrates directions into single-cycle move pulses,
// drives the engine's level select and reload reset, and advances from level 1
// to level 2 after a displayed win.
//
// Configuration macro:
//   GAME_FLOW_AUTO_REPEAT_EN - when defined, a held direction re-issues its
//                              move each time COOLDOWN expires (no release
//                              needed). Default build: release-to-rearm.
//
// Parameters:
//   DEB_CYCLES      - debounce stability window
//   COOLDOWN_CYCLES - dead time after each issued move
//   LOAD_CYCLES     - cycles map_rst_n is held low per (re)load, minimum 2
//   WIN_HOLD_CYCLES - cycles WIN is shown before advancing
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   btn_up/down/left/right     - synchronised raw direction buttons
//   btn_restart                - synchronised raw restart button
//   win_flag                   - win indication from the map engine
//   move_up/down/left/right    - one-cycle move pulses to the map engine
//   map_sel                    - level select (0 = level 1, 1 = level 2)
//   map_rst_n                  - active-low reload for the map engine
//   game_state                 - current state encoding
//   game_done                  - high once level 2 has been won
// -----------------------------------------------------------------------------
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter logic [19:0] DEB_CYCLES      = 20'd500000,
    parameter logic [15:0] COOLDOWN_CYCLES = 16'd1000,
    parameter logic [3:0]  LOAD_CYCLES     = 4'd8,
    parameter logic [27:0] WIN_HOLD_CYCLES = 28'd100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_restart,
    input  logic       win_flag,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic       map_sel,
    output logic       map_rst_n,
    output logic [2:0] game_state,
    output logic       game_done
);

    // ---------------------------------------------------------------- debounce
    logic db_up, db_down, db_left, db_right, db_restart;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(clk), .rst_n(rst_n), .raw(btn_up), .level(db_up)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk(clk), .rst_n(rst_n), .raw(btn_down), .level(db_down)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
        .clk(clk), .rst_n(rst_n), .raw(btn_left), .level(db_left)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
        .clk(clk), .rst_n(rst_n), .raw(btn_right), .level(db_right)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_restart (
        .clk(clk), .rst_n(rst_n), .raw(btn_restart), .level(db_restart)
    );

    // ---------------------------------------------------------------- state
    game_state_t state_q, state_d;
    logic [3:0]  load_cnt_q, load_cnt_d;
    logic [15:0] cool_cnt_q, cool_cnt_d;
    logic [27:0] win_cnt_q, win_cnt_d;
    logic        map_sel_q, map_sel_d;
    logic        game_done_q, game_done_d;
    logic        armed_q, armed_d;
    logic        first_play_q, first_play_d;   // first PLAY cycle after LOAD
    dir_t        move_dir_q, move_dir_d;
    logic        restart_prev_q;

    logic restart_evt;
    logic move_ok;
    dir_t req_dir;

    assign restart_evt = db_restart & ~restart_prev_q;
    assign req_dir     = pick_dir(db_up, db_down, db_left, db_right);

`ifdef GAME_FLOW_AUTO_REPEAT_EN
    // Held directions re-fire after every cooldown; armed is not consulted.
    assign move_ok = 1'b1;
`else
    // A move needs all directions released since the previous move.
    assign move_ok = armed_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_LOAD;
            load_cnt_q     <= '0;
            cool_cnt_q     <= '0;
            win_cnt_q      <= '0;
            map_sel_q      <= 1'b0;
            game_done_q    <= 1'b0;
            armed_q        <= 1'b0;
            first_play_q   <= 1'b0;
            move_dir_q     <= DIR_NONE;
            restart_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_cnt_q     <= load_cnt_d;
            cool_cnt_q     <= cool_cnt_d;
            win_cnt_q      <= win_cnt_d;
            map_sel_q      <= map_sel_d;
            game_done_q    <= game_done_d;
            armed_q        <= armed_d;
            first_play_q   <= first_play_d;
            move_dir_q     <= move_dir_d;
            restart_prev_q <= db_restart;
        end
    end

    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        cool_cnt_d   = cool_cnt_q;
        win_cnt_d    = win_cnt_q;
        map_sel_d    = map_sel_q;
        game_done_d  = game_done_q;
        first_play_d = 1'b0;
        move_dir_d   = DIR_NONE;

        unique case (state_q)
            S_LOAD: begin
                if (restart_evt) begin
                    load_cnt_d = '0;
                end else if (load_cnt_q >= LOAD_CYCLES - 4'd1) begin
                    state_d      = S_PLAY;
                    first_play_d = 1'b1;
                end else if (load_cnt_q != '1) begin
                    load_cnt_d = load_cnt_q + 4'd1;
                end
            end

            S_PLAY: begin
                if (restart_evt) begin
                    state_d    = S_LOAD;
                    load_cnt_d = '0;
                    game_done_d = 1'b0;
                end else if (win_flag && !first_play_q) begin
                    // The engine's win_flag may still reflect the old map in
                    // the first cycle after reload, hence first_play_q.
                    state_d   = S_WIN;
                    win_cnt_d = '0;
                end else if (move_ok && req_dir != DIR_NONE) begin
                    state_d    = S_COOLDOWN;
                    cool_cnt_d = '0;
                    move_dir_d = req_dir;
                end
            end

            S_COOLDOWN: begin
                if (restart_evt) begin
                    state_d     = S_LOAD;
                    load_cnt_d  = '0;
                    game_done_d = 1'b0;
                end else if (win_flag) begin
                    state_d   = S_WIN;
                    win_cnt_d = '0;
                end else if (cool_cnt_q >= COOLDOWN_CYCLES - 16'd1) begin
                    state_d = S_PLAY;
                end else if (cool_cnt_q != '1) begin
                    cool_cnt_d = cool_cnt_q + 16'd1;
                end
            end

            S_WIN: begin
                if (restart_evt) begin
                    state_d     = S_LOAD;
                    load_cnt_d  = '0;
                    game_done_d = 1'b0;
                end else if (win_cnt_q >= WIN_HOLD_CYCLES - 28'd1) begin
                    if (!map_sel_q) begin
                        // Level select changes on the same edge LOAD is
                        // entered, so it is stable for the whole reload.
                        map_sel_d  = 1'b1;
                        state_d    = S_LOAD;
                        load_cnt_d = '0;
                    end else begin
                        state_d     = S_DONE;
                        game_done_d = 1'b1;
                    end
                end else if (win_cnt_q != '1) begin
                    win_cnt_d = win_cnt_q + 28'd1;
                end
            end

            S_DONE: begin
                if (restart_evt) begin
                    state_d     = S_LOAD;
                    load_cnt_d  = '0;
                    game_done_d = 1'b0;
                end
            end

            default: begin
                state_d    = S_LOAD;
                load_cnt_d = '0;
            end
        endcase

        // armed drops on an issued move and rises once all directions are
        // released; it tracks the buttons in every state.
        if (move_dir_d != DIR_NONE)
            armed_d = 1'b0;
        else if (!(db_up || db_down || db_left || db_right))
            armed_d = 1'b1;
        else
            armed_d = armed_q;
    end

    // ---------------------------------------------------------------- outputs
    assign move_up    = (move_dir_q == DIR_UP);
    assign move_down  = (move_dir_q == DIR_DOWN);
    assign move_left  = (move_dir_q == DIR_LEFT);
    assign move_right = (move_dir_q == DIR_RIGHT);
    assign map_sel    = map_sel_q;
    assign map_rst_n  = (state_q != S_LOAD);
    assign game_state = state_q;
    assign game_done  = game_done_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_flow_ctrl
// Directed bench for game_flow_ctrl with DEB_CYCLES=4, COOLDOWN_CYCLES=8,
// LOAD_CYCLES=4, WIN_HOLD_CYCLES=16. Inputs change and outputs are sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up, btn_down, btn_left, btn_right, btn_restart, win_flag;
    logic       move_up, move_down, move_left, move_right;
    logic       map_sel, map_rst_n, game_done;
    logic [2:0] game_state;

    int total = 0;
    int bad   = 0;

    // Per-window activity counters filled by run_cycles.
    int n_up, n_down, n_left, n_right, n_multi, n_cool;
    int state_at_move;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .DEB_CYCLES     (20'd4),
        .COOLDOWN_CYCLES(16'd8),
        .LOAD_CYCLES    (4'd4),
        .WIN_HOLD_CYCLES(28'd16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_restart(btn_restart),
        .win_flag   (win_flag),
        .move_up    (move_up),
        .move_down  (move_down),
        .move_left  (move_left),
        .move_right (move_right),
        .map_sel    (map_sel),
        .map_rst_n  (map_rst_n),
        .game_state (game_state),
        .game_done  (game_done)
    );

    task automatic clear_counts();
        n_up = 0; n_down = 0; n_left = 0; n_right = 0;
        n_multi = 0; n_cool = 0; state_at_move = -1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_up    += int'(move_up);
            n_down  += int'(move_down);
            n_left  += int'(move_left);
            n_right += int'(move_right);
            if (int'(move_up) + int'(move_down) + int'(move_left) + int'(move_right) > 1)
                n_multi++;
            if (game_state == 3'd2) n_cool++;
            if (move_up || move_down || move_left || move_right)
                state_at_move = int'(game_state);
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (game_state == target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------ scenarios
    task automatic test_reset();
        int n_low;
        rst_n = 1'b0;
        {btn_up, btn_down, btn_left, btn_right, btn_restart, win_flag} = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({game_state, map_sel, map_rst_n, game_done, move_up, move_down, move_left, move_right}
            !== {3'd0, 1'b0, 1'b0, 1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL reset_values: state=%0d sel=%b mrst=%b done=%b moves=%b%b%b%b required state=0 sel=0 mrst=0 done=0 moves=0000",
                     game_state, map_sel, map_rst_n, game_done, move_up, move_down, move_left, move_right);
        end
        rst_n = 1'b1;
        n_low = 0;
        while (map_rst_n === 1'b0 && n_low < 50) begin
            n_low++;
            @(negedge clk);
        end
        total++;
        if (n_low !== 4) begin
            bad++;
            $display("FAIL load_low_cycles: got %0d required 4", n_low);
        end
        total++;
        if (game_state !== 3'd1) begin
            bad++;
            $display("FAIL reset_to_play: state=%0d required 1", game_state);
        end
        total++;
        if (map_sel !== 1'b0) begin
            bad++;
            $display("FAIL reset_map_sel: got %b required 0", map_sel);
        end
    endtask

    task automatic test_debounce_single_move();
        clear_counts();
        btn_left = 1'b1;
        run_cycles(3);
        btn_left = 1'b0;
        run_cycles(6);
        total++;
        if (n_left !== 0) begin
            bad++;
            $display("FAIL glitch_no_pulse: pulses=%0d required 0", n_left);
        end
        btn_left = 1'b1;
        run_cycles(30);
        total++;
        if (n_left !== 1) begin
            bad++;
            $display("FAIL held_single_pulse: pulses=%0d required 1", n_left);
        end
        total++;
        if (n_cool !== 8) begin
            bad++;
            $display("FAIL cooldown_length: cycles=%0d required 8", n_cool);
        end
        total++;
        if (state_at_move !== 2) begin
            bad++;
            $display("FAIL state_with_pulse: state=%0d required 2", state_at_move);
        end
        btn_left = 1'b0;
        run_cycles(10);
        btn_left = 1'b1;
        run_cycles(10);
        total++;
        if (n_left !== 2) begin
            bad++;
            $display("FAIL repress_pulse: total pulses=%0d required 2", n_left);
        end
        btn_left = 1'b0;
        run_cycles(15);
        total++;
        if (n_multi !== 0 || n_up + n_down + n_right !== 0) begin
            bad++;
            $display("FAIL left_only: multi=%0d other=%0d required 0 0", n_multi, n_up + n_down + n_right);
        end
    endtask

    task automatic test_priority();
        clear_counts();
        btn_up    = 1'b1;
        btn_right = 1'b1;
        run_cycles(20);
        total++;
        if (n_up !== 1 || n_right !== 0) begin
            bad++;
            $display("FAIL priority_up_right: up=%0d right=%0d required 1 0", n_up, n_right);
        end
        total++;
        if (n_cool !== 8) begin
            bad++;
            $display("FAIL priority_cooldown: cycles=%0d required 8", n_cool);
        end
        btn_up    = 1'b0;
        btn_right = 1'b0;
        run_cycles(10);
        total++;
        if (n_up + n_down + n_left + n_right !== 1 || n_multi !== 0) begin
            bad++;
            $display("FAIL priority_total: moves=%0d multi=%0d required 1 0",
                     n_up + n_down + n_left + n_right, n_multi);
        end
    endtask

    task automatic test_win_level1();
        int n_win, n_load;
        total++;
        if (game_state !== 3'd1) begin
            bad++;
            $display("FAIL win1_precond: state=%0d required 1", game_state);
        end
        win_flag = 1'b1;
        @(negedge clk);
        win_flag = 1'b0;
        n_win = 0;
        while (game_state === 3'd3 && n_win < 100) begin
            n_win++;
            @(negedge clk);
        end
        total++;
        if (n_win !== 16) begin
            bad++;
            $display("FAIL win1_hold: cycles=%0d required 16", n_win);
        end
        total++;
        if (game_state !== 3'd0 || map_sel !== 1'b1) begin
            bad++;
            $display("FAIL win1_advance: state=%0d sel=%b required 0 1", game_state, map_sel);
        end
        n_load = 0;
        while (map_rst_n === 1'b0 && n_load < 50) begin
            n_load++;
            @(negedge clk);
        end
        total++;
        if (n_load !== 4 || game_state !== 3'd1) begin
            bad++;
            $display("FAIL win1_reload: low=%0d state=%0d required 4 1", n_load, game_state);
        end
        // First PLAY cycle after a reload ignores win_flag.
        win_flag = 1'b1;
        @(negedge clk);
        win_flag = 1'b0;
        total++;
        if (game_state !== 3'd1) begin
            bad++;
            $display("FAIL win_first_play_ignored: state=%0d required 1", game_state);
        end
    endtask

    task automatic test_win_level2();
        int n_win;
        bit ok;
        win_flag = 1'b1;
        @(negedge clk);
        win_flag = 1'b0;
        n_win = 0;
        while (game_state === 3'd3 && n_win < 100) begin
            n_win++;
            @(negedge clk);
        end
        total++;
        if (n_win !== 16 || game_state !== 3'd4 || game_done !== 1'b1 || map_sel !== 1'b1) begin
            bad++;
            $display("FAIL win2_done: hold=%0d state=%0d done=%b sel=%b required 16 4 1 1",
                     n_win, game_state, game_done, map_sel);
        end
        clear_counts();
        btn_down = 1'b1;
        run_cycles(15);
        total++;
        if (n_down !== 0 || game_state !== 3'd4) begin
            bad++;
            $display("FAIL done_ignores_move: pulses=%0d state=%0d required 0 4", n_down, game_state);
        end
        btn_down = 1'b0;
        run_cycles(6);
        btn_restart = 1'b1;
        wait_state(3'd0, 20, ok);
        total++;
        if (!ok || map_sel !== 1'b1 || game_done !== 1'b0 || map_rst_n !== 1'b0) begin
            bad++;
            $display("FAIL done_restart: reached=%0d sel=%b done=%b mrst=%b required 1 1 0 0",
                     ok, map_sel, game_done, map_rst_n);
        end
        btn_restart = 1'b0;
        wait_state(3'd1, 20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL done_restart_play: state=%0d required 1", game_state);
        end
        run_cycles(15);
    endtask

    task automatic test_restart_priority();
        bit ok;
        clear_counts();
        btn_restart = 1'b1;
        btn_up      = 1'b1;
        run_cycles(4);
        win_flag = 1'b1;
        run_cycles(1);
        win_flag = 1'b0;
        total++;
        if (game_state !== 3'd0 || map_sel !== 1'b1 || n_up !== 0) begin
            bad++;
            $display("FAIL restart_priority: state=%0d sel=%b up=%0d required 0 1 0",
                     game_state, map_sel, n_up);
        end
        btn_restart = 1'b0;
        btn_up      = 1'b0;
        wait_state(3'd1, 20, ok);
        run_cycles(15);
    endtask

    task automatic test_async_reset();
        bit seen;
        bit ok;
        seen = 1'b0;
        btn_right = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (move_right) begin
                seen = 1'b1;
                break;
            end
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (!seen || game_state !== 3'd2) begin
            bad++;
            $display("FAIL midcool_precond: pulse=%0d state=%0d required 1 2", seen, game_state);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({game_state, map_sel, map_rst_n, game_done, move_up, move_down, move_left, move_right}
            !== {3'd0, 1'b0, 1'b0, 1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL midcool_reset: state=%0d sel=%b mrst=%b done=%b required 0 0 0 0",
                     game_state, map_sel, map_rst_n, game_done);
        end
        btn_right = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_state(3'd1, 20, ok);
        total++;
        if (!ok || map_sel !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_play: reached=%0d sel=%b required 1 0", ok, map_sel);
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_debounce_single_move();
        test_priority();
        test_win_level1();
        test_win_level2();
        test_restart_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Sequences the pushbox map engine: debounces the four direction buttons and the restart button, and arbitrates them into single-cycle move pulses. Drives the engine's level-select and reload-reset, and advances from level 1 to level 2 on a win. Sits between the board button inputs and the map engine, which takes move_*, map_sel and rst_n and returns win_flag.

Parameters:
DEB_CYCLES, 20'd500000, consecutive stable cycles required before a debounced level changes
COOLDOWN_CYCLES, 16'd1000, dead time after each issued move
LOAD_CYCLES, 4'd8, cycles map_rst_n is held low for a level (re)load; minimum 2
WIN_HOLD_CYCLES, 28'd100000000, cycles WIN is displayed before advancing the level

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
btn_up  in  1  raw button level, already 2-FF synchronised
btn_down  in  1  raw button level, already synchronised
btn_left  in  1  raw button level, already synchronised
btn_right  in  1  raw button level, already synchronised
btn_restart  in  1  raw button level, already synchronised
win_flag  in  1  win indication from map engine
move_up  out  1  one-cycle move pulse
move_down  out  1  one-cycle move pulse
move_left  out  1  one-cycle move pulse
move_right  out  1  one-cycle move pulse
map_sel  out  1  level select: 0 = level 1, 1 = level 2
map_rst_n  out  1  active-low reload for map engine
game_state  out  3  current FSM state encoding
game_done  out  1  high once level 2 is won

Behaviour:
- Reset values: move_* = 0, map_sel = 0, map_rst_n = 0, game_done = 0, state = LOAD, load counter = 0, all debounced levels = 0, armed = 0.
- Debounce, per button: counter clears whenever raw level equals the debounced level. Otherwise it increments; on reaching DEB_CYCLES-1 the debounced level flips and the counter clears.
- Restart event: rising edge of debounced restart.
- FSM states: LOAD=0, PLAY=1, COOLDOWN=2, WIN=3, DONE=4.
- LOAD:
  - map_rst_n = 0 for exactly LOAD_CYCLES cycles; map_sel is stable throughout.
  - Then map_rst_n = 1 and go to PLAY.
  - move_* are held 0.
- Arbitration:
  - armed is set when all four debounced directions are 0; it is cleared when a move is issued.
  - In PLAY with armed=1, the highest-priority asserted direction wins: up > down > left > right.
  - The corresponding move_* pulses high for exactly 1 cycle, in the cycle after the debounced level is sampled; state goes to COOLDOWN.
  - At most one move_* is high in any cycle. No move is issued while armed=0 (no auto-repeat).
- COOLDOWN: counts COOLDOWN_CYCLES, then returns to PLAY. Direction inputs are ignored except for updating armed.
- Win:
  - win_flag=1 sampled in PLAY or COOLDOWN -> WIN, with the counter cleared.
  - win_flag is ignored in LOAD and during the first cycle of PLAY after LOAD.
- WIN: after WIN_HOLD_CYCLES:
  - if map_sel=0: set map_sel=1 and go to LOAD;
  - if map_sel=1: go to DONE and set game_done=1.
- DONE: holds; only a restart event leaves it.
- Restart event in any state except LOAD:
  - go to LOAD, clear game_done, keep map_sel. A restart in DONE therefore reloads level 2.
  - Restart has priority over win_flag and over a move in the same cycle.
- A restart event during LOAD restarts the load counter.
- Any cycle of rst_n low returns every register to its reset value immediately, mid-debounce or mid-count included.
- Counter widths: each counter is as wide as its parameter; counters saturate and never wrap.

Optional Feature:
Macro: GAME_FLOW_AUTO_REPEAT_EN.
- Defined: a direction held continuously reissues its move each time COOLDOWN expires, with no release needed; armed is ignored. Priority and the one-pulse-per-cycle rule still apply.
- Undefined: release-to-rearm behaviour exactly as above.

Decomposition:
- Package game_pkg holds:
  - FSM state localparams (LOAD..DONE, 3-bit);
  - direction encoding DIR_NONE/UP/DOWN/LEFT/RIGHT;
  - map geometry constants MAP_W=7, MAP_H=8, MAP_CELLS=56, shared with the map engine and display;
  - tile codes WALL=0, BOX=1, CHEST=2, FLOOR=3, KEY=4, PLAYER=6, GOAL=8.
- Sub-module btn_debounce (parameter DEB_CYCLES), instantiated 5 times. Arbitration, FSM and counters stay in game_flow_ctrl.

Test Plan:
All scenarios use DEB_CYCLES=4, COOLDOWN_CYCLES=8, LOAD_CYCLES=4, WIN_HOLD_CYCLES=16.
1. Release rst_n -> map_rst_n low for exactly 4 cycles, then high; game_state goes 0 -> 1; map_sel=0.
2. Raw btn_left glitches high for 3 cycles, then held high 10 cycles -> no pulse from the glitch; exactly one move_left pulse of 1 cycle; none until release and re-press.
3. btn_up and btn_right rise in the same cycle -> only move_up pulses; no further move during the 8 COOLDOWN cycles.
4. win_flag=1 in PLAY at level 1 -> state WIN for 16 cycles, map_sel becomes 1, map_rst_n low 4 cycles, then PLAY.
5. Win at level 2 -> game_done=1, state DONE; a direction press gives no pulse; restart -> LOAD with map_sel=1, game_done=0.
6. Restart and win_flag asserted in the same cycle in PLAY -> LOAD taken, map_sel unchanged. rst_n pulsed low mid-COOLDOWN -> all outputs return to reset values in that cycle.
